seq_shift_add_mul: RTL and testbench

//   Parametrised sequential shift-add multiplier with integrated datapath and control.

---
 rtl/seq_mul_pkg.sv | 31 +++
 rtl/seq_mul_ctrl.sv | 67 ++++++
 rtl/seq_shift_add_mul.sv | 111 +++++++++++
 tb/tb_seq_shift_add_mul.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// ============================================================================
// Module      : seq_mul_pkg
// Description : Shared FSM state type and sizing helper for the sequential
//               shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mul_ctrl.sv
// ============================================================================
// Module      : seq_mul_ctrl
// Description : IDLE/RUN/DONE sequencer for the shift-add multiplier; issues
//               the operand load, per-cycle shift and the done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_ctrl
    import seq_mul_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic cnt_last,
    output logic load,
    output logic shift,
    output logic done,
    output logic busy
);

    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        load        = 1'b0;
        shift       = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load        = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                shift = 1'b1;
                if (cnt_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            // start is deliberately ignored here so requests are never queued
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seq_shift_add_mul.sv
// ============================================================================
// Module      : seq_shift_add_mul
// Description : Parametrised sequential shift-add multiplier, one partial
//               product per clock. Define SEQ_MUL_SIGNED_EN for two's
//               complement operands (same ports and latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_add_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                 c_cnt_w    = clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    logic [WIDTH:0]       r_m;
    logic [WIDTH:0]       r_acc;
    logic [WIDTH-1:0]     r_q;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_load;
    logic                 w_shift;
    logic                 w_cnt_last;
    logic [WIDTH:0]       w_m_ext;
    logic [WIDTH:0]       w_sum;
    logic                 w_fill;
    logic [WIDTH:0]       w_acc_nxt;
    logic [WIDTH-1:0]     w_q_nxt;

    assign w_cnt_last = (r_cnt == c_cnt_last);

    seq_mul_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cnt_last (w_cnt_last),
        .load     (w_load),
        .shift    (w_shift),
        .done     (done),
        .busy     (busy)
    );

    always_comb begin
        w_m_ext = '0;
        w_sum   = '0;
        w_fill  = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
        w_m_ext = {multiplicand[WIDTH-1], multiplicand};
        // The multiplier MSB carries weight -2^(W-1), so its partial product is subtracted.
        if (r_q[0] && w_cnt_last) begin
            w_sum = r_acc - r_m;
        end else if (r_q[0]) begin
            w_sum = r_acc + r_m;
        end else begin
            w_sum = r_acc;
        end
        w_fill = w_sum[WIDTH];
`else
        w_m_ext = {1'b0, multiplicand};
        w_sum   = r_q[0] ? (r_acc + r_m) : r_acc;
        w_fill  = 1'b0;
`endif
        w_acc_nxt = {w_fill, w_sum[WIDTH:1]};
        w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_m   <= w_m_ext;
            r_acc <= '0;
            r_q   <= multiplier;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Result register only moves on the final shift, so it is stable mid-run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_product <= '0;
        end else if (w_shift && w_cnt_last) begin
            r_product <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
        end
    end

    assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_mul.sv
// ============================================================================
// Module      : tb_seq_shift_add_mul
// Description : Directed self-checking bench for seq_shift_add_mul (W=8);
//               expectations follow SEQ_MUL_SIGNED_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shift_add_mul;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int errors = 0;
    int checks = 0;

    seq_shift_add_mul #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MUL_SIGNED_EN
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    // done high while idle is never legal
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(done === 1'b1 && busy !== 1'b1)) else begin
                errors++;
                $error("FAIL done_while_idle: observed done=%0b busy=%0b expected busy=1", done, busy);
            end
        end
    end

    // One transaction. n counts negedges after the accept edge E0 (first one is n=1);
    // done is seen at n=W+1, i.e. in the cycle closed by edge E(W+1).
    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp, input logic [2*W-1:0] prev);
        int n;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (n == 4) check({tag, "_held"}, 32'(product), 32'(prev));
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(W + 1));
        check({tag, "_product"}, 32'(product), 32'(exp));
        @(negedge clk);
        check({tag, "_pulse"}, 32'({done, busy}), 32'd0);
        check({tag, "_stable"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int pulses;
        int busy_gap;
        logic [2*W-1:0] p1;
        logic [2*W-1:0] p2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        rst = 1'b0;

        run_mul("m13x11", 8'd13, 8'd11, 16'd143, 16'd0);
`ifdef SEQ_MUL_SIGNED_EN
        run_mul("m255x255", 8'd255, 8'd255, 16'h0001, 16'd143);
`else
        run_mul("m255x255", 8'd255, 8'd255, 16'hFE01, 16'd143);
`endif
        run_mul("m0x200", 8'd0, 8'd200, 16'd0, model(8'd255, 8'd255));

        // start held high with operands changing every cycle
        pulses   = 0;
        busy_gap = 0;
        p1       = '0;
        p2       = '0;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) p1 = product;
                if (pulses == 2) p2 = product;
            end
            if ((n == 10 || n == 20) && busy === 1'b0) busy_gap++;
            multiplicand = W'(n + 20);
            multiplier   = W'(n + 40);
        end
        start = 1'b0;
        check("hold_pulses", 32'(pulses), 32'd3);
        check("hold_idle_gaps", 32'(busy_gap), 32'd2);
        check("hold_first_product", 32'(p1), 32'd63);
        check("hold_second_product", 32'(p2), 32'd1500);
        repeat (2) @(negedge clk);

        // synchronous reset in the middle of 100*100
        start        = 1'b1;
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_mul("m3x3", 8'd3, 8'd3, 16'd9, 16'd0);

`ifdef SEQ_MUL_SIGNED_EN
        run_mul("s_m3x5", 8'hFD, 8'd5, 16'hFFF1, 16'd9);
        run_mul("s_m128xm128", 8'h80, 8'h80, 16'h4000, 16'hFFF1);
        run_mul("s_127xm1", 8'd127, 8'hFF, 16'hFF81, 16'h4000);
`endif

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_mul($sformatf("rand%0d", i), ra, rb, model(ra, rb), product);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
